// File: rtl/sim_mem_responder.sv
// Memory-side responder for the core's 64-bit request/response interface.
// Serves one outstanding access at a time, with a fixed access latency and error flagging.
module sim_mem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h1000,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] access_count
);

  localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [63:0] mem [DEPTH_WORDS];

  logic        l_write;
  logic [63:0] l_addr;
  logic [63:0] l_wdata;
  logic [7:0]  l_wmask;
  logic [3:0]  cnt;

  logic        accept;
  logic        do_access;
  logic        acc_write;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic [7:0]  acc_wmask;
  logic [63:0] bit_mask;
  logic [60:0] word_idx;
  logic [1:0]  acc_err;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // With LATENCY==1 the acceptance edge is also the edge entering RESP,
  // so the access is performed on the live request rather than the latched copy.
  always_comb begin
    acc_write = l_write;
    acc_addr  = l_addr;
    acc_wdata = l_wdata;
    acc_wmask = l_wmask;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
    do_access = ((state == WAIT) && (cnt == 4'd1)) || (accept && (LATENCY == 1));
    word_idx  = acc_addr[63:3] - BASE_ADDR[63:3];
    if (acc_addr[2:0] != 3'b000)
      acc_err = 2'd1;
    else if ((acc_addr < BASE_ADDR) || (word_idx >= 61'(DEPTH_WORDS)))
      acc_err = 2'd2;
    else
      acc_err = 2'd0;
    bit_mask = {{8{acc_wmask[7]}}, {8{acc_wmask[6]}}, {8{acc_wmask[5]}}, {8{acc_wmask[4]}},
                {8{acc_wmask[3]}}, {8{acc_wmask[2]}}, {8{acc_wmask[1]}}, {8{acc_wmask[0]}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= '0;
      access_count <= '0;
      cnt          <= '0;
      l_write      <= 1'b0;
      l_addr       <= '0;
      l_wdata      <= '0;
      l_wmask      <= '0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[IDXW'(i)] <= '0;
    end else begin
      if (do_access) begin
        resp_err   <= acc_err;
        resp_rdata <= (!acc_write && (acc_err == 2'd0)) ? mem[word_idx[IDXW-1:0]] : '0;
        if (acc_write && (acc_err == 2'd0))
          mem[word_idx[IDXW-1:0]] <= (mem[word_idx[IDXW-1:0]] & ~bit_mask) | (acc_wdata & bit_mask);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            l_write   <= req_write;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            l_wmask   <= req_wmask;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            req_ready    <= 1'b1;
            access_count <= access_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_mem_responder.sv
// Directed bench for sim_mem_responder: a LATENCY=2 and a LATENCY=1 instance,
// checked against a reference memory model through an expected-response queue.
module tb_sim_mem_responder;

  localparam logic [63:0] BASE  = 64'h1000;
  localparam int unsigned DEPTH = 512;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic        resp_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;

  logic        rv_a, rv_b, rr_a, rr_b, vs_a, vs_b, rs_a, rs_b;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  er_a, er_b;
  logic [31:0] ac_a, ac_b;

  logic        cur_req_ready, cur_resp_valid;
  logic [63:0] cur_rdata;
  logic [1:0]  cur_err;
  logic [31:0] cur_count;

  exp_t        sb[$];
  logic [63:0] model [2][DEPTH];
  int unsigned exp_count [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rv_a = req_valid && !sel;
  assign rv_b = req_valid && sel;
  assign rs_a = resp_ready && !sel;
  assign rs_b = resp_ready && sel;
  assign cur_req_ready  = sel ? rr_b : rr_a;
  assign cur_resp_valid = sel ? vs_b : vs_a;
  assign cur_rdata      = sel ? rd_b : rd_a;
  assign cur_err        = sel ? er_b : er_a;
  assign cur_count      = sel ? ac_b : ac_a;

  sim_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rr_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vs_a), .resp_ready(rs_a), .resp_rdata(rd_a), .resp_err(er_a),
    .access_count(ac_a));

  sim_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rr_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(vs_b), .resp_ready(rs_b), .resp_rdata(rd_b), .resp_err(er_b),
    .access_count(ac_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) model[s][i] = '0;
      exp_count[s] = 0;
    end
    sb.delete();
  endtask

  // Drives one request on the selected instance, then holds the response for
  // 'hold' extra cycles before completing the handshake.
  task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m, input int hold);
    exp_t e;
    int   n;
    int   edges;
    int   lat;
    int   idx;
    lat     = sel ? 1 : 2;
    e.rdata = '0;
    if (a[2:0] != 3'b000) e.err = 2'd1;
    else if (a < BASE || a >= BASE + 64'(8 * DEPTH)) e.err = 2'd2;
    else e.err = 2'd0;
    if (e.err == 2'd0) begin
      idx = int'((a - BASE) >> 3);
      if (!wr) e.rdata = model[sel][idx];
      else
        for (int b = 0; b < 8; b++)
          if (m[b]) model[sel][idx][8*b +: 8] = d[8*b +: 8];
    end
    sb.push_back(e);

    req_write = wr; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", 64'(cur_req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d; req_wmask = ~m;
    @(negedge clk);
    edges = 1;
    while (!cur_resp_valid && edges < 40) begin @(negedge clk); edges++; end
    check("latency", 64'(edges), 64'(lat));
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("resp_rdata", cur_rdata, e.rdata);
      check("resp_err", 64'(cur_err), 64'(e.err));
      check("resp_valid_held", 64'(cur_resp_valid), 64'd1);
      check("req_ready_busy", 64'(cur_req_ready), 64'd0);
      if (i < hold) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    exp_count[sel]++;
    @(negedge clk);
    check("resp_valid_drop", 64'(cur_resp_valid), 64'd0);
    check("req_ready_after", 64'(cur_req_ready), 64'd1);
    check("access_count", 64'(cur_count), 64'(exp_count[sel]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(rr_a), 64'd1);
    check("rst_resp_valid", 64'(vs_a), 64'd0);
    check("rst_count", 64'(ac_a), 64'd0);
    check("rst_rdata", rd_a, 64'd0);
    check("rst_err", 64'(er_a), 64'd0);

    do_req(1'b0, 64'h1000, 64'h0, 8'h00, 0);
    do_req(1'b1, 64'h1008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
    do_req(1'b0, 64'h1008, 64'h0, 8'h00, 0);
    do_req(1'b1, 64'h1010, 64'h11223344_55667788, 8'hFF, 0);
    do_req(1'b1, 64'h1010, 64'hAAAAAAAA_AAAAAAAA, 8'h0F, 0);
    do_req(1'b0, 64'h1010, 64'h0, 8'h00, 0);
    do_req(1'b0, 64'h1004, 64'h0, 8'h00, 0);
    do_req(1'b1, 64'h0FF8, 64'h12345678_9ABCDEF0, 8'hFF, 0);
    do_req(1'b1, 64'h1009, 64'h55555555_55555555, 8'hFF, 0);
    do_req(1'b0, 64'h1008, 64'h0, 8'h00, 0);
    do_req(1'b0, 64'h2000, 64'h0, 8'h00, 0);
    do_req(1'b1, 64'h1FF8, 64'hFEDCBA98_76543210, 8'hFF, 0);
    do_req(1'b1, 64'h1FF8, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0);
    do_req(1'b0, 64'h1FF8, 64'h0, 8'h00, 0);
    do_req(1'b0, 64'h1008, 64'h0, 8'h00, 5);

    // Abort a write while it is in WAIT: nothing may be stored or answered.
    req_write = 1'b1; req_addr = BASE; req_wdata = 64'h5; req_wmask = 8'hFF; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 64'(rr_a), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", 64'(vs_a), 64'd0);
      @(negedge clk);
    end
    check("abort_count", 64'(ac_a), 64'd0);
    do_req(1'b0, 64'h1000, 64'h0, 8'h00, 0);
    do_req(1'b0, 64'h1008, 64'h0, 8'h00, 0);

    sel = 1'b1;
    @(negedge clk);
    do_req(1'b1, 64'h1000, 64'h5, 8'hFF, 0);
    do_req(1'b0, 64'h1000, 64'h0, 8'h00, 2);
    do_req(1'b0, 64'h0FF8, 64'h0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
